alu_cmd_driver: RTL and testbench

Initiator side of the ALU execute/done interface. It accepts operation commands over a valid/ready channel and reads operands from a small local register file. It drives the ALU's operand, opcode and execute lines, waits for done with a timeout, optionally writes the result back, then returns the result and flags over a valid/ready response channel. It sits between a host/sequencer and one simple_alu instance of matching WIDTH.

---
 rtl/alu_cmd_driver.sv | 147 ++++++++++++++
 tb/tb_alu_cmd_driver.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command-driven initiator for a simple execute/done ALU: fetches operands from a
// 4-entry register file, strobes execute, waits for done with timeout, returns a response.
module alu_cmd_driver #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [1:0]       cmd_src_a,
    input  logic [1:0]       cmd_src_b,
    input  logic [1:0]       cmd_dst,
    input  logic             cmd_wb,
    input  logic             reg_wr_en,
    input  logic [1:0]       reg_wr_addr,
    input  logic [WIDTH-1:0] reg_wr_data,
    input  logic [1:0]       reg_rd_addr,
    output logic [WIDTH-1:0] reg_rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_execute,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    input  logic             alu_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       OP_CMP   = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       dst_q;
    logic             wb_q;
    logic [WIDTH-1:0] regs [4];

    logic cmd_fire;
    logic done_hit;
    logic timeout_hit;
    logic wb_fire;

    assign cmd_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);
    assign busy        = (state != S_IDLE);
    assign reg_rd_data = regs[reg_rd_addr];

    assign cmd_fire    = cmd_valid && (state == S_IDLE);
    assign done_hit    = (state == S_WAIT) && alu_done;
    assign timeout_hit = (state == S_WAIT) && !alu_done && (wait_cnt == CNT_LAST);
    assign wb_fire     = done_hit && wb_q && (alu_opcode != OP_CMP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (alu_done || (wait_cnt == CNT_LAST)) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU drive, wait counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            alu_execute <= 1'b0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
            wait_cnt    <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            // Strobe is high exactly during the ISSUE cycle
            alu_execute <= cmd_fire;
            if (cmd_fire) begin
                alu_a      <= regs[cmd_src_a];
                alu_b      <= regs[cmd_src_b];
                alu_opcode <= cmd_opcode;
                dst_q      <= cmd_dst;
                wb_q       <= cmd_wb;
            end
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && !alu_done) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (done_hit) begin
                rsp_result  <= alu_result;
                rsp_flags   <= alu_flags;
                rsp_timeout <= 1'b0;
            end else if (timeout_hit) begin
                rsp_result  <= '0;
                rsp_flags   <= '0;
                rsp_timeout <= 1'b1;
            end
        end
    end

    // Register file: writeback takes priority over a host write to the same entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wb_fire && (dst_q == 2'(i))) begin
                    regs[i] <= alu_result;
                end else if (reg_wr_en && (reg_wr_addr == 2'(i))) begin
                    regs[i] <= reg_wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: stub ALU with programmable done delay,
// transaction-level register/response model, directed cases plus random commands.
module tb_alu_cmd_driver;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic [1:0]   cmd_src_a;
    logic [1:0]   cmd_src_b;
    logic [1:0]   cmd_dst;
    logic         cmd_wb;
    logic         reg_wr_en;
    logic [1:0]   reg_wr_addr;
    logic [W-1:0] reg_wr_data;
    logic [1:0]   reg_rd_addr;
    logic [W-1:0] reg_rd_data;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_opcode;
    logic         alu_execute;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         alu_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_timeout;
    logic         busy;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] mregs [4];
    logic         host_rand = 1'b0;

    int           stub_k = 0;
    logic         stub_mute = 1'b0;
    logic [W-1:0] stub_result = '0;
    logic [3:0]   stub_flags = '0;
    logic         inject_done = 1'b0;

    alu_cmd_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_wb(cmd_wb),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_execute(alu_execute),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stub ALU: done is seen by the driver stub_k edges after the first WAIT edge
    initial begin
        logic prev;
        logic pending;
        int   cnt;
        prev = 1'b0; pending = 1'b0; cnt = 0;
        alu_done = 1'b0; alu_result = '0; alu_flags = '0;
        forever begin
            @(posedge clk); #1;
            alu_done   = 1'b0;
            alu_result = W'($urandom);
            alu_flags  = 4'($urandom);
            if (!rst_n) begin
                pending = 1'b0;
                prev    = 1'b0;
            end else begin
                if (prev && !alu_execute && !stub_mute) begin
                    pending = 1'b1;
                    cnt     = stub_k;
                end
                prev = alu_execute;
                if (inject_done) begin
                    alu_done    = 1'b1;
                    inject_done = 1'b0;
                end else if (pending) begin
                    if (cnt == 0) begin
                        alu_done   = 1'b1;
                        alu_result = stub_result;
                        alu_flags  = stub_flags;
                        pending    = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input logic we, input logic [1:0] wa, input logic [W-1:0] wd);
        reg_wr_en   = we;
        reg_wr_addr = wa;
        reg_wr_data = wd;
        @(posedge clk); #1;
        if (we) mregs[wa] = wd;
        reg_wr_en   = 1'b0;
        reg_wr_addr = 2'($urandom);
        reg_wr_data = W'($urandom);
    endtask

    task automatic tick_rand();
        if (host_rand && ($urandom_range(0, 3) == 0))
            tick(1'b1, 2'($urandom), W'($urandom));
        else
            tick(1'b0, 2'd0, '0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            reg_rd_addr = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(reg_rd_data), 32'(mregs[i]));
        end
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] dst, input logic wb);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_src_a = sa; cmd_src_b = sb;
        cmd_dst = dst; cmd_wb = wb;
    endtask

    task automatic idle_cmd();
        cmd_valid = 1'b0; cmd_opcode = 4'($urandom); cmd_src_a = 2'($urandom);
        cmd_src_b = 2'($urandom); cmd_dst = 2'($urandom); cmd_wb = 1'($urandom);
    endtask

    // One full command; frc puts a host write on the completion edge, inj >= 0 injects a stray done in RESP
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [1:0] dst, input logic wb,
                           input int k, input logic mute, input int rsp_dly,
                           input logic [W-1:0] res, input logic [3:0] flg,
                           input logic frc, input logic [1:0] frc_addr, input logic [W-1:0] frc_data,
                           input int inj);
        logic [W-1:0] ea, eb, er;
        logic [3:0]   ef;
        logic         eto;
        int           exp_n, n;
        stub_k = k; stub_mute = mute; stub_result = res; stub_flags = flg;
        eto   = mute || (k >= int'(TO));
        exp_n = eto ? int'(TO) : k + 1;
        er    = eto ? '0 : res;
        ef    = eto ? 4'd0 : flg;
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        ea = mregs[sa];
        eb = mregs[sb];
        drive_cmd(op, sa, sb, dst, wb);
        tick_rand();
        idle_cmd();
        chk({tag, "_issue"}, 32'({alu_execute, cmd_ready, alu_opcode, alu_a, alu_b}),
            32'({1'b1, 1'b0, op, ea, eb}));
        tick_rand();
        chk({tag, "_exec_low"}, 32'(alu_execute), 32'd0);
        n = 0;
        while (n < int'(TO) + 3) begin
            n++;
            if (frc && (n == exp_n)) tick(1'b1, frc_addr, frc_data);
            else tick_rand();
            if ((n == exp_n) && !eto && wb && (op != OP_CMP)) mregs[dst] = res;
            if (rsp_valid) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_timeout, rsp_flags, rsp_result}),
            32'({1'b1, eto, ef, er}));
        chk({tag, "_hold_ops"}, 32'({alu_opcode, alu_a, alu_b}), 32'({op, ea, eb}));
        for (int i = 0; i < rsp_dly; i++) begin
            if (i == inj) inject_done = 1'b1;
            tick_rand();
            chk({tag, "_rsp_hold"},
                32'({rsp_valid, cmd_ready, rsp_timeout, rsp_flags, rsp_result}),
                32'({1'b1, 1'b0, eto, ef, er}));
        end
        rsp_ready = 1'b1;
        tick_rand();
        rsp_ready = 1'b0;
        chk({tag, "_done"}, 32'({rsp_valid, cmd_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
        check_regs(tag);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0; reg_rd_addr = 2'd0;
        reg_wr_en = 1'b0; reg_wr_addr = 2'd0; reg_wr_data = '0;
        idle_cmd();
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'({alu_execute, alu_opcode, alu_a, alu_b}), 32'd0);
        chk("reset_rsp", 32'({rsp_valid, rsp_timeout, rsp_flags, rsp_result}), 32'd0);
        chk("reset_ctl", 32'({cmd_ready, busy}), 32'({1'b1, 1'b0}));
        check_regs("reset");
        rst_n = 1'b1;
        tick(1'b0, 2'd0, '0);

        // ADD 0x7F + 0x01 with writeback to r2
        tick(1'b1, 2'd0, 8'h7F);
        tick(1'b1, 2'd1, 8'h01);
        run_cmd("add", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0, 1'b0, 0, 8'h80, 4'b0101,
                1'b0, 2'd0, '0, -1);

        // CMP never writes back
        tick(1'b1, 2'd0, 8'h05);
        tick(1'b1, 2'd1, 8'h05);
        tick(1'b1, 2'd3, 8'h33);
        run_cmd("cmp", OP_CMP, 2'd0, 2'd1, 2'd3, 1'b1, 1, 1'b0, 1, 8'h80, 4'b1000,
                1'b0, 2'd0, '0, -1);

        // Silent ALU: timeout, then a stray done two cycles into RESP
        run_cmd("tmo", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0, 1'b1, 5, 8'h55, 4'b1111,
                1'b0, 2'd0, '0, 1);

        // Done on the last allowed edge wins; one edge later is a timeout
        run_cmd("k_last", OP_ADD, 2'd1, 2'd0, 2'd3, 1'b1, int'(TO) - 1, 1'b0, 0, 8'hC3, 4'b0010,
                1'b0, 2'd0, '0, -1);
        run_cmd("k_over", OP_ADD, 2'd1, 2'd0, 2'd3, 1'b1, int'(TO), 1'b0, 0, 8'h3C, 4'b0100,
                1'b0, 2'd0, '0, -1);

        // Back-pressured response, then MUL
        tick(1'b1, 2'd0, 8'h10);
        tick(1'b1, 2'd1, 8'h10);
        run_cmd("bp", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 2, 1'b0, 5, 8'h20, 4'b0000,
                1'b0, 2'd0, '0, -1);
        run_cmd("mul", OP_MUL, 2'd0, 2'd1, 2'd3, 1'b1, 0, 1'b0, 0, 8'h00, 4'b1001,
                1'b0, 2'd0, '0, -1);

        // Host write colliding with writeback: same entry, then different entry
        tick(1'b1, 2'd0, 8'h7F);
        tick(1'b1, 2'd1, 8'h01);
        run_cmd("coll_same", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 0, 1'b0, 0, 8'h80, 4'b0101,
                1'b1, 2'd2, 8'hAA, -1);
        run_cmd("coll_diff", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 3, 1'b0, 0, 8'h80, 4'b0101,
                1'b1, 2'd1, 8'hAA, -1);

        // Reset while the execute strobe is high
        tick(1'b1, 2'd2, 8'h3C);
        drive_cmd(OP_ADD, 2'd2, 2'd2, 2'd1, 1'b1);
        tick(1'b0, 2'd0, '0);
        idle_cmd();
        chk("rst_iss_pre", 32'(alu_execute), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_iss", 32'({alu_execute, rsp_valid, cmd_ready}), 32'({1'b0, 1'b0, 1'b1}));
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        check_regs("rst_iss");
        tick(1'b0, 2'd0, '0);
        tick(1'b0, 2'd0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 2'd0, '0);
            chk("rst_iss_after", 32'({rsp_valid, cmd_ready}), 32'({1'b0, 1'b1}));
        end

        // Reset while waiting for done
        tick(1'b1, 2'd0, 8'h11);
        tick(1'b1, 2'd3, 8'h99);
        stub_mute = 1'b1;
        drive_cmd(OP_ADD, 2'd0, 2'd3, 2'd1, 1'b1);
        tick(1'b0, 2'd0, '0);
        idle_cmd();
        repeat (5) tick(1'b0, 2'd0, '0);
        chk("rst_wait_pre", 32'({busy, rsp_valid}), 32'({1'b1, 1'b0}));
        rst_n = 1'b0;
        #1;
        chk("rst_wait", 32'({alu_execute, rsp_valid, cmd_ready, busy}),
            32'({1'b0, 1'b0, 1'b1, 1'b0}));
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        check_regs("rst_wait");
        tick(1'b0, 2'd0, '0);
        tick(1'b0, 2'd0, '0);
        rst_n = 1'b1;
        inject_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 2'd0, '0);
            chk("rst_wait_after", 32'({rsp_valid, cmd_ready}), 32'({1'b0, 1'b1}));
        end
        check_regs("rst_wait_after");

        // Randomized commands with background host writes
        host_rand = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int   kk;
            logic mt;
            mt = ($urandom_range(0, 7) == 0);
            kk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TO - 2, TO))
                                             : int'($urandom_range(0, 5));
            run_cmd("rnd", 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    1'($urandom), kk, mt, int'($urandom_range(0, 3)), W'($urandom),
                    4'($urandom), 1'b0, 2'd0, '0, -1);
        end
        host_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
